// File: rtl/ecc_pkg.sv
// ecc_pkg: constants and types shared by the ECC flash-side blocks.
//   PAGE_BYTES  - bytes per encoded page (data + spare)
//   state_t     - flash_page_emu replay FSM encoding
package ecc_pkg;

  localparam int unsigned DATA_BYTES  = 512;
  localparam int unsigned SPARE_BYTES = 16;
  localparam int unsigned PAGE_BYTES  = DATA_BYTES + SPARE_BYTES;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/flash_page_ram.sv
// flash_page_ram: simple dual-port synchronous page RAM.
// Ports:
//   clk        - clock
//   we/wa/wd   - write enable, address, data
//   re/ra      - read enable, address
//   rd         - registered read data (updated only when re is high)
// Contents and the read register are not reset.
module flash_page_ram
  import ecc_pkg::*;
#(
  parameter int unsigned DEPTH = PAGE_BYTES,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/flash_page_emu.sv
// flash_page_emu: flash-side responder for the ECC controller byte interface.
// Captures one page streamed by eccCntl and replays it on request, with an
// optional single-byte XOR error injector on the replay path.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   flashDataValid    - qualifies flashDi (one byte captured per cycle)
//   flashDi           - write byte
//   readStart         - pulse: start replay of the stored page
//   pageClear         - pulse: rewind write pointer, clear status (IDLE only)
//   errEnable/errAdrs/errMask - injector controls, sampled at replay start
//   flashDo, flashDoValid     - replay byte and its qualifier
//   pageFull          - PAGE_BYTES bytes captured
//   overflow          - sticky: a valid byte was dropped
//   busy              - replay in progress
module flash_page_emu #(
  parameter int unsigned PAGE_BYTES = ecc_pkg::PAGE_BYTES,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flashDataValid,
  input  logic [DW-1:0] flashDi,
  input  logic          readStart,
  input  logic          pageClear,
  input  logic          errEnable,
  input  logic [AW-1:0] errAdrs,
  input  logic [DW-1:0] errMask,
  output logic [DW-1:0] flashDo,
  output logic          flashDoValid,
  output logic          pageFull,
  output logic          overflow,
  output logic          busy
);

  import ecc_pkg::*;

  localparam logic [AW-1:0] END_PTR = AW'(PAGE_BYTES);

  state_t        state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          err_en_s;
  logic [AW-1:0] err_adrs_s;
  logic [DW-1:0] err_mask_s;
  logic          out_valid;
  logic          inj_hit;
  logic [DW-1:0] ram_q;
  logic          wr_en, rd_en;

  // pageClear takes priority over a same-cycle capture.
  assign wr_en = (state == IDLE) && flashDataValid && !pageClear && (wr_ptr < END_PTR);
  assign rd_en = (state == READ) && (rd_ptr != END_PTR);

  flash_page_ram #(
    .DEPTH (PAGE_BYTES),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk (clk),
    .we  (wr_en),
    .wa  (wr_ptr),
    .wd  (flashDi),
    .re  (rd_en),
    .ra  (rd_ptr),
    .rd  (ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // READ lasts PAGE_BYTES+1 cycles: one per array read, plus the cycle that
  // retires the last registered byte.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (readStart) state_nx = READ;
      READ:    if (rd_ptr == END_PTR) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      err_en_s   <= 1'b0;
      err_adrs_s <= '0;
      err_mask_s <= '0;
      out_valid  <= 1'b0;
      inj_hit    <= 1'b0;
    end else begin
      if ((state == IDLE) && pageClear) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        // Any valid byte not written (page full, or replay running) is lost.
        if (flashDataValid && !wr_en) overflow <= 1'b1;
      end

      if ((state == IDLE) && readStart) begin
        rd_ptr     <= '0;
        err_en_s   <= errEnable;
        err_adrs_s <= errAdrs;
        err_mask_s <= errMask;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      // Qualifier and injector hit are registered alongside the RAM read so
      // they line up with ram_q.
      out_valid <= rd_en;
      inj_hit   <= rd_en && err_en_s && (rd_ptr == err_adrs_s);
    end
  end

  assign flashDo      = out_valid ? (ram_q ^ (inj_hit ? err_mask_s : '0)) : '0;
  assign flashDoValid = out_valid;
  assign pageFull     = (wr_ptr == END_PTR);
  assign busy         = (state == READ);

endmodule

// File: tb/tb_flash_page_emu.sv
// tb_flash_page_emu: directed self-checking bench for flash_page_emu.
module tb_flash_page_emu;

  localparam int PAGE = 528;

  logic       clk = 1'b0;
  logic       reset;
  logic       flashDataValid;
  logic [7:0] flashDi;
  logic       readStart;
  logic       pageClear;
  logic       errEnable;
  logic [9:0] errAdrs;
  logic [7:0] errMask;
  logic [7:0] flashDo;
  logic       flashDoValid;
  logic       pageFull;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_mem [PAGE];

  flash_page_emu #(
    .PAGE_BYTES (528),
    .AW         (10),
    .DW         (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flashDataValid (flashDataValid),
    .flashDi        (flashDi),
    .readStart      (readStart),
    .pageClear      (pageClear),
    .errEnable      (errEnable),
    .errAdrs        (errAdrs),
    .errMask        (errMask),
    .flashDo        (flashDo),
    .flashDoValid   (flashDoValid),
    .pageFull       (pageFull),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i <= 255) ? b : ~b;
  endfunction

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      flashDataValid = 1'b1;
      flashDi        = (i < PAGE) ? pat(i) : 8'h77;
      tick();
      if (i == PAGE - 2) check("full_early", pageFull, 0);
      if (i == PAGE - 1) begin
        check("full_set", pageFull, 1);
        check("ovf_at_full", overflow, 0);
      end
      if (i == PAGE) check("ovf_set", overflow, 1);
    end
    flashDataValid = 1'b0;
  endtask

  // Replays the page and compares every byte with the model. poke drives
  // readStart and flashDataValid mid-replay; wr_start captures wr_byte in the
  // start cycle; abort_at >= 0 asserts reset right after byte abort_at.
  task automatic replay(input bit en, input logic [9:0] adrs, input logic [7:0] mask,
                        input bit poke, input bit wr_start, input logic [7:0] wr_byte,
                        input int abort_at);
    logic [7:0] exp;
    errEnable = en;
    errAdrs   = adrs;
    errMask   = mask;
    readStart = 1'b1;
    if (wr_start) begin
      flashDataValid = 1'b1;
      flashDi        = wr_byte;
    end
    tick();
    readStart      = 1'b0;
    flashDataValid = 1'b0;
    // Injector inputs moved after start must not affect this replay.
    errEnable = 1'b1;
    errAdrs   = 10'd5;
    errMask   = 8'hFF;
    check("start_busy", busy, 1);
    check("start_valid", flashDoValid, 0);
    check("start_do", flashDo, 0);
    for (int k = 0; k < PAGE; k++) begin
      if (poke && k == 10) readStart = 1'b1;
      if (poke && k == 20) begin
        flashDataValid = 1'b1;
        flashDi        = 8'h55;
      end
      tick();
      readStart      = 1'b0;
      flashDataValid = 1'b0;
      exp = exp_mem[k];
      if (en && adrs == 10'(k)) exp = exp ^ mask;
      check("rd_valid", flashDoValid, 1);
      check("rd_byte", flashDo, exp);
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("abort_valid", flashDoValid, 0);
        check("abort_busy", busy, 0);
        check("abort_do", flashDo, 0);
        errEnable = 1'b0;
        return;
      end
    end
    tick();
    check("end_valid", flashDoValid, 0);
    check("end_busy", busy, 0);
    check("end_do", flashDo, 0);
    errEnable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < PAGE; i++) exp_mem[i] = pat(i);
    reset          = 1'b0;
    flashDataValid = 1'b0;
    flashDi        = '0;
    readStart      = 1'b0;
    pageClear      = 1'b0;
    errEnable      = 1'b0;
    errAdrs        = '0;
    errMask        = '0;
    tick();
    tick();
    check("rst_do", flashDo, 0);
    check("rst_valid", flashDoValid, 0);
    check("rst_full", pageFull, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Fill and clean replay (0x00 at k=0, 0xFF at k=256, 0xF0 at k=527).
    stream(PAGE);
    check("pat_256", exp_mem[256], 8'hFF);
    replay(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00, -1);

    // Injection at 171 and an out-of-page injection address.
    replay(1'b1, 10'd171, 8'hAB, 1'b0, 1'b0, 8'h00, -1);
    replay(1'b1, 10'd600, 8'hAB, 1'b0, 1'b0, 8'h00, -1);

    // readStart and a data byte during READ.
    replay(1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 8'h00, -1);
    check("poke_ovf", overflow, 1);
    check("poke_full", pageFull, 1);

    // Reset mid-replay, then replay the preserved array.
    replay(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00, 100);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_full", pageFull, 0);
    check("post_rst_ovf", overflow, 0);
    check("post_rst_busy", busy, 0);
    replay(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00, -1);

    // Overflow with 530 bytes; the first 528 must survive.
    stream(PAGE + 2);
    check("ovf_full", pageFull, 1);
    replay(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00, -1);
    check("ovf_sticky", overflow, 1);

    // pageClear with a same-cycle byte: clear wins, byte dropped silently.
    pageClear      = 1'b1;
    flashDataValid = 1'b1;
    flashDi        = 8'hEE;
    tick();
    pageClear      = 1'b0;
    flashDataValid = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_full", pageFull, 0);
    flashDataValid = 1'b1;
    flashDi        = 8'h3C;
    tick();
    flashDataValid = 1'b0;
    exp_mem[0] = 8'h3C;
    check("clr_wr_full", pageFull, 0);
    check("clr_wr_ovf", overflow, 0);

    // readStart together with a captured byte (lands at index 1).
    exp_mem[1] = 8'h5A;
    replay(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 8'h5A, -1);
    check("rs_wr_ovf", overflow, 0);
    check("rs_wr_full", pageFull, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
